// File: rtl/wb_pkg.sv
// Shared types and defaults for the writeback source selector.
package wb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } wb_state_t;

  localparam int WB_N_SRC_DEF   = 8;
  localparam int WB_WIDTH_DEF   = 32;
  localparam int WB_TIMEOUT_DEF = 64;

  function automatic int wb_cnt_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/wb_select_unit_mux.sv
// Indexed source/ready select; out-of-range index yields zeros.
module wb_src_mux #(
    parameter int N_SRC = 8,
    parameter int WIDTH = 32
) (
    input  logic [N_SRC*WIDTH-1:0]   src_data,
    input  logic [N_SRC-1:0]         src_ready,
    input  logic [$clog2(N_SRC)-1:0] sel,
    output logic [WIDTH-1:0]         data,
    output logic                     ready,
    output logic                     oor
);

    localparam int SEL_W = $clog2(N_SRC);

    assign oor = int'(sel) >= N_SRC;

    always_comb begin
        data  = '0;
        ready = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (sel == SEL_W'(i)) begin
                data  = src_data[i*WIDTH +: WIDTH];
                ready = src_ready[i];
            end
        end
    end

endmodule

// File: rtl/wb_select_unit.sv
// Registered writeback source select with readiness wait,
// bounded timeout and illegal-select error reporting.
module wb_select_unit
    import wb_pkg::*;
#(
    parameter int N_SRC   = WB_N_SRC_DEF,
    parameter int WIDTH   = WB_WIDTH_DEF,
    parameter int TIMEOUT = WB_TIMEOUT_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_SRC*WIDTH-1:0]   src_data,
    input  logic [N_SRC-1:0]         src_ready,
    input  logic                     wb_req,
    input  logic [$clog2(N_SRC)-1:0] wb_sel,
    output logic                     wb_busy,
    output logic [WIDTH-1:0]         wb_data,
    output logic                     wb_valid,
    output logic                     wb_err
);

    localparam int SEL_W = $clog2(N_SRC);
    localparam int CW    = wb_cnt_w(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    wb_state_t        state, state_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic [SEL_W-1:0] lsel, lsel_d;
    logic [WIDTH-1:0] data_d;
    logic             valid_d, err_d;

    logic [SEL_W-1:0] m_sel;
    logic [WIDTH-1:0] m_data;
    logic             m_ready, m_oor;
    logic             last;

    // In WAIT the latched index drives the mux, never the live select.
    assign m_sel = (state == WAIT) ? lsel : wb_sel;
    assign last  = (cnt == CNT_LAST);

    wb_src_mux #(
        .N_SRC(N_SRC),
        .WIDTH(WIDTH)
    ) u_mux (
        .src_data (src_data),
        .src_ready(src_ready),
        .sel      (m_sel),
        .data     (m_data),
        .ready    (m_ready),
        .oor      (m_oor)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            lsel     <= '0;
            wb_data  <= '0;
            wb_valid <= 1'b0;
            wb_err   <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            lsel     <= lsel_d;
            wb_data  <= data_d;
            wb_valid <= valid_d;
            wb_err   <= err_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        lsel_d  = lsel;
        unique case (state)
            IDLE: begin
                if (wb_req && !m_oor && !m_ready) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                    lsel_d  = wb_sel;
                end
            end
            WAIT: begin
                if (m_ready || last) state_d = IDLE;
                else                 cnt_d   = cnt + CW'(1);
            end
        endcase
    end

    // Ready is checked before timeout so a coinciding ready wins.
    always_comb begin
        data_d  = wb_data;
        valid_d = 1'b0;
        err_d   = 1'b0;
        unique case (state)
            IDLE: begin
                if (wb_req) begin
                    unique case (1'b1)
                        m_oor: begin
                            valid_d = 1'b1;
                            err_d   = 1'b1;
                            data_d  = '0;
                        end
                        m_ready: begin
                            valid_d = 1'b1;
                            data_d  = m_data;
                        end
                        default: ;
                    endcase
                end
            end
            WAIT: begin
                if (m_ready) begin
                    valid_d = 1'b1;
                    data_d  = m_data;
                end else if (last) begin
                    valid_d = 1'b1;
                    err_d   = 1'b1;
                end
            end
        endcase
    end

    assign wb_busy = (state == WAIT);

endmodule

// File: tb/tb_wb_select_unit.sv
// Directed bench for wb_select_unit with a cycle-stamped scoreboard.
module tb_wb_select_unit;

    localparam int N  = 6;
    localparam int W  = 32;
    localparam int TO = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic [N*W-1:0] src_data;
    logic [N-1:0]   src_ready;
    logic           wb_req;
    logic [2:0]     wb_sel;
    logic           wb_busy;
    logic [W-1:0]   wb_data;
    logic           wb_valid;
    logic           wb_err;

    typedef struct {
        int          cyc;
        logic [31:0] d;
        logic        e;
    } exp_t;

    exp_t        q[$];
    exp_t        me;
    int          cyc    = 0;
    int          ncomp  = 0;
    int          nfail  = 0;
    bit          mon_on = 1'b0;
    logic [31:0] last_d;
    int          t;

    wb_select_unit #(
        .N_SRC  (N),
        .WIDTH  (W),
        .TIMEOUT(TO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .src_data (src_data),
        .src_ready(src_ready),
        .wb_req   (wb_req),
        .wb_sel   (wb_sel),
        .wb_busy  (wb_busy),
        .wb_data  (wb_data),
        .wb_valid (wb_valid),
        .wb_err   (wb_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %h want %h (cyc %0d)",
                   tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic [31:0] d);
        src_data[i*W +: W] = d;
    endtask

    task automatic push(input int c, input logic [31:0] d,
                        input logic e);
        exp_t x;
        x.cyc = c;
        x.d   = d;
        x.e   = e;
        q.push_back(x);
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (q.size() > 0 && q[0].cyc == cyc) begin
                me = q.pop_front();
                chk("valid", 32'(wb_valid), 32'd1);
                chk("data", wb_data, me.d);
                chk("err", 32'(wb_err), 32'(me.e));
            end else begin
                chk("no_valid", 32'(wb_valid), 32'd0);
                chk("no_err", 32'(wb_err), 32'd0);
            end
        end
    end

    initial begin
        reset     = 1'b0;
        wb_req    = 1'b1;
        wb_sel    = 3'd2;
        src_ready = '1;
        for (int i = 0; i < N; i++) set_src(i, 32'hA000_0000 | 32'(i));

        // reset held with a pending request
        for (int k = 0; k < 3; k++) begin
            step();
            mon_on = 1'b1;
            chk("rst_busy", 32'(wb_busy), 32'd0);
            chk("rst_data", wb_data, 32'd0);
            chk("rst_valid", 32'(wb_valid), 32'd0);
        end
        reset  = 1'b1;
        wb_req = 1'b0;
        step();

        // back-to-back hits, then two illegal selects
        for (int s = 0; s < 8; s++) begin
            wb_req = 1'b1;
            wb_sel = 3'(s);
            if (s < N) last_d = 32'hA000_0000 | 32'(s);
            else       last_d = 32'd0;
            push(cyc + 1, last_d, s >= N);
            step();
            chk("hit_busy", 32'(wb_busy), 32'd0);
        end
        wb_req = 1'b0;

        // restore nonzero data before the wait cases
        wb_req = 1'b1;
        wb_sel = 3'd2;
        last_d = 32'hA000_0002;
        push(cyc + 1, last_d, 1'b0);
        step();
        wb_req = 1'b0;

        // wait then ready at t+5, data changes when ready rises
        src_ready[4] = 1'b0;
        set_src(4, 32'h1111_1111);
        wb_sel = 3'd4;
        wb_req = 1'b1;
        t = cyc;
        step();
        wb_req = 1'b0;
        for (int k = 1; k < 5; k++) begin
            chk("wait_busy", 32'(wb_busy), 32'd1);
            step();
        end
        set_src(4, 32'h2222_2222);
        src_ready[4] = 1'b1;
        last_d = 32'h2222_2222;
        push(t + 6, last_d, 1'b0);
        chk("wait_busy5", 32'(wb_busy), 32'd1);
        step();
        chk("wait_done", 32'(wb_busy), 32'd0);
        chk("wait_lat", 32'(cyc), 32'(t + 6));

        // timeout with an ignored request mid-wait
        src_ready[5] = 1'b0;
        wb_sel = 3'd5;
        wb_req = 1'b1;
        t = cyc;
        push(t + TO + 1, last_d, 1'b1);
        step();
        wb_req = 1'b0;
        for (int k = 1; k <= TO; k++) begin
            chk("to_busy", 32'(wb_busy), 32'd1);
            wb_req = (k == 3);
            wb_sel = (k == 3) ? 3'd0 : 3'd5;
            step();
        end
        wb_req = 1'b0;
        chk("to_idle", 32'(wb_busy), 32'd0);
        step();

        // illegal select after nonzero data
        wb_sel = 3'd6;
        wb_req = 1'b1;
        last_d = 32'd0;
        push(cyc + 1, last_d, 1'b1);
        step();
        wb_req = 1'b0;
        chk("ill_busy", 32'(wb_busy), 32'd0);

        // ready on the last wait cycle beats the timeout
        src_ready[1] = 1'b0;
        wb_sel = 3'd1;
        wb_req = 1'b1;
        t = cyc;
        step();
        wb_req = 1'b0;
        for (int k = 1; k < TO; k++) step();
        set_src(1, 32'hCAFE_F00D);
        src_ready[1] = 1'b1;
        last_d = 32'hCAFE_F00D;
        push(t + TO + 1, last_d, 1'b0);
        chk("coin_busy", 32'(wb_busy), 32'd1);
        step();

        // reset during WAIT aborts silently
        src_ready[3] = 1'b0;
        wb_sel = 3'd3;
        wb_req = 1'b1;
        step();
        wb_req = 1'b0;
        step();
        reset = 1'b0;
        step();
        chk("rw_busy", 32'(wb_busy), 32'd0);
        chk("rw_data", wb_data, 32'd0);
        reset = 1'b1;
        src_ready[3] = 1'b1;
        repeat (4) step();

        // normal service after the abort
        wb_req = 1'b1;
        push(cyc + 1, 32'hA000_0003, 1'b0);
        step();
        wb_req = 1'b0;
        repeat (2) step();

        chk("sb_empty", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncomp, nfail);
        $finish;
    end

endmodule
